mult_word_packer: RTL and testbench

- Serial-to-parallel frame packer that sits directly upstream of the pairwise multiply/adder-tree stage.
- Accepts one signed NB_DATA word per cycle on a valid/ready handshake and assembles N_WORDS words into the flat N_WORDS*NB_DATA bus that the multiplier consumes.
- Double-buffered: an assembly buffer fills while the previous frame is held on the output register. The result is zero-bubble streaming at one word per cycle when downstream is always ready.

---
 rtl/mult_word_packer.sv | 92 +++++++++
 tb/tb_mult_word_packer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_word_packer.sv
// Serial-to-parallel frame packer feeding the pairwise multiplier tree.
// One word per cycle fills an assembly buffer; full frames move to a held output register.
module mult_word_packer #(
    parameter int N_WORDS = 16,
    parameter int NB_DATA = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NB_DATA-1:0]           i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic                         i_clear,
    output logic [N_WORDS*NB_DATA-1:0]   o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [$clog2(N_WORDS):0]     o_word_cnt
);

    localparam int CW = $clog2(N_WORDS) + 1;
    localparam int W  = N_WORDS * NB_DATA;
    localparam logic [CW-1:0] FULL = CW'(N_WORDS);
    localparam logic [CW-1:0] LAST = CW'(N_WORDS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  asm_q, asm_d;
    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;

    logic accept, free, pending;

    assign pending = (cnt_q == FULL);
    assign o_ready = !pending && !i_clear;
    assign accept  = i_valid && o_ready;
    assign free    = !valid_q || i_ready;

    always_comb begin
        asm_d   = asm_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;

        for (int k = 0; k < N_WORDS; k++) begin
            if (accept && cnt_q == CW'(k))
                asm_d[k*NB_DATA +: NB_DATA] = i_data;
        end

        // Consumption drops valid unless a new frame lands below.
        if (valid_q && i_ready)
            valid_d = 1'b0;

        if (i_clear) begin
            cnt_d = '0;
        end else if (pending) begin
            if (i_ready) begin
                data_d  = asm_q;
                valid_d = 1'b1;
                cnt_d   = '0;
            end
        end else if (accept) begin
            if (cnt_q == LAST) begin
                if (free) begin
                    data_d  = asm_d;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = FULL;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            asm_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_word_cnt = cnt_q;

endmodule

// File: tb/tb_mult_word_packer.sv
// Randomized and directed bench for mult_word_packer against a queue-based frame model.
// Every cycle compares o_ready, o_valid, o_data and o_word_cnt with the model.
module tb_mult_word_packer;

    localparam int N  = 16;
    localparam int NB = 8;
    localparam int CW = $clog2(N) + 1;
    localparam int W  = N * NB;

    logic          clock = 1'b0;
    logic          reset;
    logic [NB-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic          i_clear;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic          i_ready;
    logic [CW-1:0] o_word_cnt;

    mult_word_packer #(.N_WORDS(N), .NB_DATA(NB)) dut (
        .clock      (clock),
        .reset      (reset),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_clear    (i_clear),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_word_cnt (o_word_cnt)
    );

    always #5 clock = ~clock;

    logic [NB-1:0] mq[$];
    logic [W-1:0]  m_data;
    bit            m_valid;
    int            n_vec;
    int            n_err;
    int            cyc_n;
    int            pulses[$];

    task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] pack_q();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            r[i*NB +: NB] = mq[i];
        return r;
    endfunction

    function automatic int dot(logic [W-1:0] f);
        int  s;
        byte a;
        byte b;
        s = 0;
        for (int i = 0; i < N/2; i++) begin
            a = f[(2*i)*NB +: NB];
            b = f[(2*i+1)*NB +: NB];
            s += int'(a) * int'(b);
        end
        return s;
    endfunction

    task automatic step(bit rst, bit vld, logic [NB-1:0] d, bit rdy, bit clr);
        bit cons;
        bit free;
        bit done;
        @(negedge clock);
        reset   = rst;
        i_valid = vld;
        i_data  = d;
        i_ready = rdy;
        i_clear = clr;
        #1;
        check("o_ready", W'(o_ready), W'((mq.size() != N) && !clr));
        @(posedge clock);
        if (rst) begin
            mq.delete();
            m_data  = '0;
            m_valid = 0;
        end else begin
            cons = m_valid && rdy;
            free = !m_valid || rdy;
            done = 0;
            if (clr) begin
                mq.delete();
            end else if (mq.size() == N) begin
                if (rdy) begin
                    m_data = pack_q();
                    mq.delete();
                    done = 1;
                end
            end else if (vld) begin
                mq.push_back(d);
                if (mq.size() == N && free) begin
                    m_data = pack_q();
                    mq.delete();
                    done = 1;
                end
            end
            if (done)
                m_valid = 1;
            else if (cons)
                m_valid = 0;
        end
        #1;
        cyc_n++;
        check("o_valid", W'(o_valid), W'(m_valid));
        check("o_data", o_data, m_data);
        check("o_word_cnt", W'(o_word_cnt), W'(mq.size()));
        if (o_valid)
            pulses.push_back(cyc_n);
    endtask

    task automatic drain();
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 0);
    endtask

    logic [W-1:0] fr;
    logic [W-1:0] held;

    initial begin
        n_vec = 0;
        n_err = 0;
        cyc_n = 0;
        reset = 1; i_valid = 0; i_data = '0; i_ready = 0; i_clear = 0;
        m_data = '0;
        m_valid = 0;

        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        check("rst_cnt", W'(o_word_cnt), '0);
        check("rst_valid", W'(o_valid), '0);

        // Single frame 0x01..0x10
        drain();
        pulses.delete();
        for (int k = 1; k <= N; k++)
            step(0, 1, 8'(k), 1, 0);
        fr = o_data;
        check("sf_valid", W'(o_valid), W'(1));
        check("sf_w0", W'(fr[7:0]), W'(8'h01));
        check("sf_w15", W'(fr[W-1 -: NB]), W'(8'h10));
        check("sf_dot", W'(dot(fr)), W'(744));
        step(0, 0, 8'h00, 1, 0);
        check("sf_pulses", W'(pulses.size()), W'(1));

        // Reset mid-frame
        for (int k = 0; k < 5; k++)
            step(0, 1, 8'(8'hA0 + k), 1, 0);
        step(1, 1, 8'hFF, 1, 0);
        check("rm_cnt", W'(o_word_cnt), '0);
        check("rm_valid", W'(o_valid), '0);
        check("rm_data", o_data, '0);
        for (int k = 0; k < N; k++)
            step(0, 1, 8'(8'h30 + k), 1, 0);
        check("rm_w0", W'(o_data[7:0]), W'(8'h30));

        // Backpressure: two frames, second pends
        drain();
        for (int k = 1; k <= 2*N; k++)
            step(0, 1, 8'(k), 0, 0);
        check("bp_cnt", W'(o_word_cnt), W'(N));
        check("bp_f1_w0", W'(o_data[7:0]), W'(8'h01));
        step(0, 1, 8'hEE, 0, 0);
        check("bp_cnt33", W'(o_word_cnt), W'(N));
        step(0, 0, 8'h00, 1, 0);
        for (int k = 0; k < N; k++)
            fr[k*NB +: NB] = 8'(17 + k);
        check("bp_f2", o_data, fr);
        check("bp_valid", W'(o_valid), W'(1));
        step(0, 0, 8'h00, 1, 0);

        // Streaming 64 words
        drain();
        pulses.delete();
        for (int k = 0; k < 4*N; k++)
            step(0, 1, 8'($urandom), 1, 0);
        check("st_pulses", W'(pulses.size()), W'(4));
        for (int i = 1; i < pulses.size(); i++)
            check("st_gap", W'(pulses[i] - pulses[i-1]), W'(N));

        // Clear with held frame
        drain();
        for (int k = 0; k < N; k++)
            step(0, 1, 8'(8'h50 + k), 0, 0);
        held = o_data;
        for (int k = 0; k < 7; k++)
            step(0, 1, 8'(8'h70 + k), 0, 0);
        step(0, 1, 8'hCC, 0, 1);
        check("cl_cnt", W'(o_word_cnt), '0);
        check("cl_valid", W'(o_valid), W'(1));
        check("cl_data", o_data, held);

        // Signed frame
        drain();
        for (int k = 0; k < N; k++)
            step(0, 1, (k % 2 == 0) ? 8'h80 : 8'h7F, 1, 0);
        check("sg_w1", W'(o_data[15:8]), W'(8'h7F));
        check("sg_dot", W'(dot(o_data)), W'(-130048));

        // Random traffic
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 70,
                 8'($urandom), $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
